// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its operand-issue stage.
// Opcode encodings must stay in step with the combinational ALU.
// Widths here are the defaults picked up by the issue stage and register file.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int OP_W    = 3;
  localparam int REG_CNT = 16;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLL = 3'd5;
  localparam logic [OP_W-1:0] OP_SRL = 3'd6;
  localparam logic [OP_W-1:0] OP_7   = 3'd7;

endpackage

// File: rtl/alu_operand_issue_if.sv
// Command, ALU and writeback bundle between requester/ALU and the issue stage.
// master: command source plus the ALU; slave: the issue stage.
// cmd_valid/cmd_ready handshake; the ALU side has no backpressure.
interface alu_operand_issue_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int ADDR_W = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] cmd_rd;

  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_out;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, alu_out,
    input  cmd_ready, alu_in1, alu_in2, alu_op, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, alu_out,
    output cmd_ready, alu_in1, alu_in2, alu_op, wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/alu_regfile.sv
// Register file: two operand read ports, one debug read port, register 0 reads 0.
// Reads are combinational; writes land on the rising edge.
// Load and writeback share the write logic; writeback wins on an address clash.
module alu_regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  import alu_pkg::*;

  logic [DATA_W-1:0] regs [REG_CNT];

  // Per-register write select; entry 0 is only ever written by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < REG_CNT; i++) begin
        if (wb_en && wb_addr == ADDR_W'(i))      regs[i] <= wb_data;
        else if (ld_en && ld_addr == ADDR_W'(i)) regs[i] <= ld_data;
      end
    end
  end

  assign rdata1    = (raddr1 == '0)    ? '0 : regs[raddr1];
  assign rdata2    = (raddr2 == '0)    ? '0 : regs[raddr2];
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/alu_operand_issue.sv
// Issue stage for the combinational ALU: regfile read -> E (ALU operands) -> W (writeback).
// Latency: command to regfile update is 2 edges; one command per cycle sustained.
// cmd_ready drops during loads, and on RAW hazards unless ALU_ISSUE_BYPASS_EN is defined.
module alu_operand_issue #(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int OP_W    = alu_pkg::OP_W,
  parameter int REG_CNT = alu_pkg::REG_CNT,
  parameter int ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  alu_operand_issue_if.slave io
);
  import alu_pkg::*;

  logic              e_valid;
  logic [ADDR_W-1:0] e_rd;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic [DATA_W-1:0] opnd1, opnd2;
  logic              haz1, haz2;
  logic              accept;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (io.cmd_rs1),
    .rdata1   (rdata1),
    .raddr2   (io.cmd_rs2),
    .rdata2   (rdata2),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata),
    .ld_en    (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_en    (e_valid),
    .wb_addr  (e_rd),
    .wb_data  (io.alu_out)
  );

  // A source hazards when it names the register the E stage is about to write.
  assign haz1 = e_valid && (e_rd != '0) && (io.cmd_rs1 == e_rd);
  assign haz2 = e_valid && (e_rd != '0) && (io.cmd_rs2 == e_rd);

  // Operand select and acceptance: forward from the ALU, or hold the command for one cycle.
  always_comb begin
    opnd1        = rdata1;
    opnd2        = rdata2;
    io.cmd_ready = !ld_valid;
`ifdef ALU_ISSUE_BYPASS_EN
    if (haz1) opnd1 = io.alu_out;
    if (haz2) opnd2 = io.alu_out;
`else
    if (haz1 || haz2) io.cmd_ready = 1'b0;
`endif
  end

  assign accept = io.cmd_valid && io.cmd_ready;

  // E stage: capture operands on accept; operands hold when idle so the ALU inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.alu_in1 <= '0;
      io.alu_in2 <= '0;
      io.alu_op  <= '0;
      e_rd       <= '0;
      e_valid    <= 1'b0;
    end else begin
      e_valid <= accept;
      if (accept) begin
        io.alu_in1 <= opnd1;
        io.alu_in2 <= opnd2;
        io.alu_op  <= io.cmd_op;
        e_rd       <= io.cmd_rd;
      end
    end
  end

  // W stage: report the writeback performed at this edge (rd 0 still pulses).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.wb_valid <= 1'b0;
      io.wb_rd    <= '0;
      io.wb_data  <= '0;
    end else begin
      io.wb_valid <= e_valid;
      if (e_valid) begin
        io.wb_rd   <= e_rd;
        io.wb_data <= io.alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue with a behavioural ALU on the alu_out side.
// Inputs change just after the falling edge; outputs are sampled before the next rising edge.
// Expected stall count on dependent pairs follows ALU_ISSUE_BYPASS_EN.
module tb_alu_operand_issue;
  import alu_pkg::*;

  localparam int AW = $clog2(REG_CNT);
`ifdef ALU_ISSUE_BYPASS_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [AW-1:0]     dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;

  int checks = 0;
  int errors = 0;
  int stalls;

  alu_operand_issue_if #(.DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(AW)) ifc ();

  alu_operand_issue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata),
    .io       (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                              input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  assign ifc.alu_out = alu_f(ifc.alu_in1, ifc.alu_in2, ifc.alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", tag, got, got, want, want);
    end
  endtask

  task automatic load_reg(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    #1 check("ld_cmd_ready", ifc.cmd_ready, 0);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic drive_cmd(input logic [OP_W-1:0] op, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_rs1   = rs1;
    ifc.cmd_rs2   = rs2;
    ifc.cmd_rd    = rd;
  endtask

  task automatic dbg_check(input string tag, input logic [AW-1:0] a, input logic [DATA_W-1:0] want);
    dbg_raddr = a;
    #1 check(tag, dbg_rdata, want);
  endtask

  initial begin
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_raddr = '0;
    ifc.cmd_valid = 1'b0; ifc.cmd_op = '0; ifc.cmd_rs1 = '0; ifc.cmd_rs2 = '0; ifc.cmd_rd = '0;

    // 1. reset state
    #2;
    check("rst_alu_in1", ifc.alu_in1, 0);
    check("rst_alu_in2", ifc.alu_in2, 0);
    check("rst_alu_op", ifc.alu_op, 0);
    check("rst_wb_valid", ifc.wb_valid, 0);
    check("rst_wb_rd", ifc.wb_rd, 0);
    check("rst_wb_data", ifc.wb_data, 0);
    check("rst_cmd_ready", ifc.cmd_ready, 1);
    check("rst_dbg", dbg_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1b. reset between accept and writeback
    load_reg(1, 5);
    drive_cmd(OP_ADD, 1, 1, 6);
    #1 check("r1_ready", ifc.cmd_ready, 1);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("r1_in1_pre", ifc.alu_in1, 5);
    rst_n = 1'b0;
    #1 check("r1_in1_async", ifc.alu_in1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("r1_no_wb_a", ifc.wb_valid, 0);
    @(negedge clk);
    check("r1_no_wb_b", ifc.wb_valid, 0);
    dbg_check("r1_r6", 6, 0);
    dbg_check("r1_r1", 1, 0);

    // 2. load and add
    load_reg(1, 154345);
    load_reg(2, 23167);
    drive_cmd(OP_ADD, 1, 2, 3);
    #1 check("t2_ready", ifc.cmd_ready, 1);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("t2_in1", ifc.alu_in1, 154345);
    check("t2_in2", ifc.alu_in2, 23167);
    check("t2_op", ifc.alu_op, OP_ADD);
    check("t2_wb_early", ifc.wb_valid, 0);
    @(negedge clk);
    check("t2_wb_valid", ifc.wb_valid, 1);
    check("t2_wb_rd", ifc.wb_rd, 3);
    check("t2_wb_data", ifc.wb_data, 177512);
    dbg_check("t2_r3", 3, 177512);
    @(negedge clk);
    check("t2_wb_pulse", ifc.wb_valid, 0);

    // 3. dependent pair; r3 cleared first so a stale read is visible
    load_reg(3, 0);
    drive_cmd(OP_ADD, 1, 2, 3);
    #1 check("t3_ready_a", ifc.cmd_ready, 1);
    @(negedge clk);
    drive_cmd(OP_SUB, 3, 2, 4);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ifc.cmd_ready) break;
      @(negedge clk);
      stalls++;
    end
    check("t3_stalls", stalls, EXP_STALL);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("t3_in1", ifc.alu_in1, 177512);
    check("t3_op", ifc.alu_op, OP_SUB);
    @(negedge clk);
    check("t3_wb_data", ifc.wb_data, 154345);
    dbg_check("t3_r4", 4, 154345);

    // 4. rd = 0, rs1 = 0, followed by a reader of r0
    @(negedge clk);
    drive_cmd(OP_ADD, 0, 2, 0);
    @(negedge clk);
    check("t4_in1", ifc.alu_in1, 0);
    check("t4_in2", ifc.alu_in2, 23167);
    drive_cmd(OP_ADD, 0, 1, 7);
    #1 check("t4_no_stall", ifc.cmd_ready, 1);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("t4_wb_valid", ifc.wb_valid, 1);
    check("t4_wb_rd", ifc.wb_rd, 0);
    check("t4_wb_data", ifc.wb_data, 23167);
    dbg_check("t4_r0", 0, 0);
    @(negedge clk);
    check("t4_wb_rd7", ifc.wb_rd, 7);
    dbg_check("t4_r7", 7, 154345);

    // 5. load and writeback to r5 at the same edge; command held off by load
    load_reg(8, 7);
    drive_cmd(OP_ADD, 8, 0, 5);
    #1 check("t5_ready", ifc.cmd_ready, 1);
    @(negedge clk);
    drive_cmd(OP_ADD, 1, 1, 11);
    ld_valid = 1'b1; ld_addr = 5; ld_data = 32'hDEADBEEF;
    #1 check("t5_ld_ready", ifc.cmd_ready, 0);
    @(negedge clk);
    ld_valid = 1'b0;
    check("t5_wb_rd", ifc.wb_rd, 5);
    check("t5_no_accept", ifc.alu_in1, 7);
    dbg_check("t5_r5", 5, 7);
    check("t5_ready_after", ifc.cmd_ready, 1);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("t5_in1", ifc.alu_in1, 154345);
    @(negedge clk);
    dbg_check("t5_r11", 11, 308690);

    // 5b. load and writeback to different registers at the same edge
    drive_cmd(OP_ADD, 1, 2, 9);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 10; ld_data = 32'h1234;
    @(negedge clk);
    ld_valid = 1'b0;
    dbg_check("t5_r9", 9, 177512);
    dbg_check("t5_r10", 10, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Upstream stage of the 32-bit combinational ALU (in1, in2, op[2:0] -> out).
- Holds a small register file and accepts register-addressed commands {op, rs1, rs2, rd} over valid/ready.
- Drives registered operands and opcode into the ALU, then writes the ALU result back to rd on the next edge.
- Two stages: E (operands registered at ALU inputs), then W (ALU result written to the register file).

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- OP_W, 3, opcode width; must match the ALU.
- REG_CNT, 16, number of registers; power of two.
- ADDR_W, $clog2(REG_CNT), register address width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  external register load strobe.
- ld_addr  in  ADDR_W  load target register.
- ld_data  in  DATA_W  load value.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  OP_W  ALU opcode.
- cmd_rs1  in  ADDR_W  source register for in1.
- cmd_rs2  in  ADDR_W  source register for in2.
- cmd_rd  in  ADDR_W  destination register.
- alu_in1  out  DATA_W  registered operand to ALU in1.
- alu_in2  out  DATA_W  registered operand to ALU in2.
- alu_op  out  OP_W  registered opcode to ALU op.
- alu_out  in  DATA_W  combinational ALU result.
- wb_valid  out  1  one-cycle pulse: a writeback occurred at the previous edge.
- wb_rd  out  ADDR_W  register written.
- wb_data  out  DATA_W  value written.
- dbg_raddr  in  ADDR_W  debug read address.
- dbg_rdata  out  DATA_W  combinational read of regs[dbg_raddr].

Behaviour:

Reset:
- rst_n low clears all registers, alu_in1/alu_in2/alu_op, e_valid, e_rd, wb_valid/wb_rd/wb_data to 0, asynchronously.
- An in-flight command is dropped; no writeback follows reset release.

Register 0:
- Hardwired to 0. Reads return 0.
- Loads and writebacks to address 0 are discarded. wb_valid still pulses, with wb_data = alu_out.

Accept (edge k, cmd_valid && cmd_ready):
- alu_in1 <= operand(rs1), alu_in2 <= operand(rs2), alu_op <= cmd_op, e_rd <= cmd_rd, e_valid <= 1.
- If no command is accepted, e_valid <= 0 and alu_in*/alu_op hold their last values.

Writeback (edge k+1, e_valid):
- regs[e_rd] <= alu_out.
- wb_valid <= 1, wb_rd <= e_rd, wb_data <= alu_out; otherwise wb_valid <= 0.
- Command-to-regfile-update latency is 2 edges; sustained throughput is 1 command/cycle.

cmd_ready:
- Low while ld_valid is high. Loads have priority; a command is never accepted in the same cycle as a load.
- Low on a RAW hazard when BYPASS_EN is undefined (see Optional Feature).
- High otherwise, including during idle cycles.
- No backpressure from the ALU side.

Load:
- ld_valid at an edge writes regs[ld_addr] <= ld_data.
- If a writeback and a load target the same address at the same edge, the writeback wins. Different addresses both write.

operand(rs):
- rs == 0 gives 0.
- Otherwise regs[rs], subject to the hazard rule below.

RAW hazard:
- Condition: e_valid && e_rd != 0 && rs == e_rd, for either source.

Optional Feature:
Macro: ALU_ISSUE_BYPASS_EN.
- Defined: on a hazard, the operand is taken from alu_out combinationally. cmd_ready is unaffected, so dependent back-to-back commands issue every cycle.
- Undefined: on a hazard, cmd_ready = 0 for that cycle. The command is accepted the next cycle, when e_valid = 0 and the register file holds the result. Each dependent pair costs one bubble.

Decomposition:
- Package alu_pkg:
  - DATA_W, OP_W constants.
  - Opcode localparams OP_ADD = 3'd0, OP_SUB = 3'd1, up to OP_7 = 3'd7, shared with the ALU.
  - Default REG_CNT.
- Sub-module alu_regfile:
  - REG_CNT x DATA_W, async reset, register 0 hardwired to zero.
  - Ports: two combinational read ports plus one debug read port; one write port that merges load and writeback with writeback priority.
- The issue/hazard/pipeline logic stays in alu_operand_issue.

Test Plan:
1. Reset with no stimulus:
   - Required: all outputs 0, cmd_ready = 1.
   - Then assert rst_n low between accept and writeback; required: no wb_valid after release and regs unchanged.
2. Load r1 = 154345, r2 = 23167, then command op = 0 (add), rs1 = 1, rs2 = 2, rd = 3:
   - Required: alu_in1 = 154345 and alu_in2 = 23167 one cycle after accept.
   - Required: wb_valid with wb_rd = 3, wb_data = 177512 the following cycle.
   - Required: dbg_rdata(3) = 177512.
3. Back-to-back dependent pair: add r3 = r1 + r2, then sub (op 1) r4 = r3 - r2:
   - With ALU_ISSUE_BYPASS_EN: both accepted on consecutive edges and r4 = 154345.
   - Without: cmd_ready low for exactly 1 cycle, then r4 = 154345.
4. Command with rd = 0 and rs1 = 0:
   - Required: alu_in1 = 0, wb_valid pulses, dbg_rdata(0) stays 0.
   - Required: a following command reading r0 does not stall.
5. Load to r5 = 0xDEADBEEF in the same cycle the writeback targets r5 = 7:
   - Required: r5 = 7.
   - Required: cmd_ready low during every ld_valid cycle.
